processor: RTL and testbench
============================

Name: processor

Overview:
- Minimal 16-bit multi-cycle processor: eight 16-bit general registers R0..R7, accumulator register A, result register G, an adder/subtractor and a single shared 16-bit bus.
- Instructions and immediates arrive on `din`; execution is sequenced by a 2-bit step counter.
- Internal bus, instruction register, step count and A/G are exported for observation.
- Sits as a standalone compute core fed by an external instruction/data source.

Parameters:
- none (data width fixed at 16; register count fixed at 8)

Ports:
- `clock`  in  1  rising-edge clock
- `resetn`  in  1  asynchronous reset, active-high despite the suffix; 1 = reset
- `din`  in  16  instruction word or immediate data
- `run`  in  1  start request, sampled in step T0
- `done`  out  1  combinational; high in the final step of an instruction
- `bus`  out  16  current value on the internal bus
- `ir`  out  9  instruction register
- `cnt`  out  2  step counter (T0..T3 = 0..3)
- `a`  out  16  register A
- `g`  out  16  register G

Behaviour:
- Instruction word: `ir` = `din[15:7]` = III XXX YYY.
  - III = opcode; XXX = destination/first operand RX; YYY = source RY.
  - `din[6:0]` is ignored.
- Opcodes:
  - 000 mv: RX ← RY
  - 001 mvi: RX ← next `din` word
  - 010 add: RX ← RX + RY
  - 011 sub: RX ← RX − RY
  - 100..111 are NOP.
- Reset (`resetn` = 1, asynchronous):
  - `cnt` = 0, `ir` = 0, R0..R7 = 0, `a` = 0, `g` = 0.
  - Hence `done` = 0 and `bus` = 0.
- Step counter:
  - Increments each clock, except in T0 where it advances only if `run` = 1.
  - Returns to 0 on any clock where `done` = 1.
  - Wraps 3 → 0.
- T0:
  - If `run` = 1: `ir` ← `din[15:7]` and `cnt` → 1.
  - If `run` = 0: hold.
  - `bus` = 0.
- T1:
  - mv: `bus` = RY, RX ← `bus`, `done` = 1.
  - mvi: `bus` = `din`, RX ← `bus`, `done` = 1.
  - add/sub: `bus` = RX, A ← `bus`.
  - NOP: `bus` = 0, `done` = 1, no write.
- T2 (add/sub only): `bus` = RY; G ← A + `bus` (add) or A − `bus` (sub), modulo 2^16, no carry/overflow flags.
- T3 (add/sub only): `bus` = G, RX ← `bus`, `done` = 1.
- Latency: mv/mvi/NOP take 2 clocks including fetch; add/sub take 4.
- `run` is ignored outside T0. `din` is only sampled in T0, or in T1 for mvi.
- RX = RY is legal: mv is a no-op; add doubles RX; sub clears RX.
- Register, A and G writes occur on the rising edge. A keeps its value after an instruction; G keeps the last result.
- Asserting reset mid-instruction aborts immediately and clears all state; no partial write survives.
- Bus mux priority: only one source per step (decoder-driven), default 0.

Test Plan:
- Reset held high → `cnt`=0, `ir`=0, `a`=0, `g`=0, `bus`=0, `done`=0 regardless of `run`/`din`.
- Release reset; `din`=16'h2800 with `run`=1, then `din`=16'h0005 with `run`=0 → T1 `bus`=5, `done`=1, R2=5, `cnt` back to 0.
- `din`=16'h1500 with `run`=1 (mv R5,R2) → T1 `bus`=5, R5=5, `done`=1.
- `din`=16'h3C00 then 16'h0006 (mvi R7,6) → R7=6; next `din`=16'h5780 (add R5,R7) → T1 `a`=5, T2 `g`=11, T3 `bus`=11, R5=11, `done`=1.
- `din`=16'h7D00 (sub R7,R2) → `a`=6, `g`=1, R7=1; repeat with R2=6, R7=5 → R7=16'hFFFF (wrap).
- `run`=0 in T0 for several clocks → `cnt` stays 0, `ir` unchanged; reset asserted in T2 of an add → all cleared, RX unmodified.

Source files
------------

// File: rtl/processor.sv
// Multi-cycle 16-bit processor: eight general registers, A/G around one adder/subtractor,
// and a single shared bus. Instructions and immediates arrive on din; cnt is the step state.
module processor (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] din,
  input  logic        run,
  output logic        done,
  output logic [15:0] bus,
  output logic [8:0]  ir,
  output logic [1:0]  cnt,
  output logic [15:0] a,
  output logic [15:0] g
);
  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // Handshake: run is a start request sampled only in T0; done is high for
  // exactly the final step of each instruction, after which the core is back in T0.
  step_t       step;
  logic [15:0] r [8];
  logic [2:0]  op, rx, ry;
  logic        addsub;

  assign op     = ir[8:6];
  assign rx     = ir[5:3];
  assign ry     = ir[2:0];
  assign addsub = (op == OP_ADD) || (op == OP_SUB);
  assign cnt    = step;

  // Bus source decoder: one driver per step, zero when nothing is selected.
  always_comb begin
    bus  = '0;
    done = 1'b0;
    case (step)
      T1: begin
        case (op)
          OP_MV: begin
            bus  = r[ry];
            done = 1'b1;
          end
          OP_MVI: begin
            bus  = din;
            done = 1'b1;
          end
          OP_ADD, OP_SUB: bus = r[rx];
          default: done = 1'b1;
        endcase
      end
      T2: if (addsub) bus = r[ry];
      T3: begin
        if (addsub) begin
          bus  = g;
          done = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      step <= T0;
      ir   <= '0;
      a    <= '0;
      g    <= '0;
      for (int i = 0; i < 8; i++) r[i] <= '0;
    end else begin
      case (step)
        T0: begin
          if (run) begin
            ir   <= din[15:7];
            step <= T1;
          end
        end
        T1: begin
          if (op == OP_MV || op == OP_MVI) r[rx] <= bus;
          if (addsub) a <= bus;
        end
        T2: if (addsub) g <= (op == OP_SUB) ? a - bus : a + bus;
        T3: if (addsub) r[rx] <= bus;
        default: ;
      endcase
      if (step != T0) step <= done ? T0 : step_t'(step + 2'd1);
    end
  end
endmodule

// File: tb/tb_processor.sv
// Bench for processor: an instruction-level model pushes the expected state at each
// completing step; a negedge monitor pops and compares whenever done is high.
module tb_processor;
  localparam int W = 59;  // {cnt, ir, bus, a, g}

  logic        clock = 1'b0;
  logic        resetn;
  logic [15:0] din;
  logic        run;
  logic        done;
  logic [15:0] bus;
  logic [8:0]  ir;
  logic [1:0]  cnt;
  logic [15:0] a;
  logic [15:0] g;

  processor dut (
    .clock  (clock),
    .resetn (resetn),
    .din    (din),
    .run    (run),
    .done   (done),
    .bus    (bus),
    .ir     (ir),
    .cnt    (cnt),
    .a      (a),
    .g      (g)
  );

  // clock / reset
  always #5 clock = ~clock;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // instruction-level reference model
  logic [15:0] m_r [8];
  logic [15:0] m_a, m_g;
  logic [8:0]  m_ir;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_a  = '0;
    m_g  = '0;
    m_ir = '0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1 with the core in T0; returns at posedge+1 back in T0.
  task automatic issue(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                       input logic [15:0] imm);
    logic [15:0] v;
    logic [1:0]  c;
    m_ir = {op, rx, ry};
    case (op)
      3'd0: begin v = m_r[ry]; m_r[rx] = v; c = 2'd1; end
      3'd1: begin v = imm; m_r[rx] = imm; c = 2'd1; end
      3'd2: begin m_a = m_r[rx]; m_g = m_a + m_r[ry]; m_r[rx] = m_g; v = m_g; c = 2'd3; end
      3'd3: begin m_a = m_r[rx]; m_g = m_a - m_r[ry]; m_r[rx] = m_g; v = m_g; c = 2'd3; end
      default: begin v = '0; c = 2'd1; end
    endcase
    exp_q.push_back({c, m_ir, v, m_a, m_g});
    din = {op, rx, ry, 7'($urandom)};
    run = 1'b1;
    @(posedge clock); #1;
    run = 1'($urandom);
    din = (op == 3'd1) ? imm : 16'($urandom);
    if (c == 2'd3) begin
      repeat (2) begin
        @(posedge clock); #1;
        run = 1'($urandom);
        din = 16'($urandom);
      end
    end
    @(posedge clock); #1;
    run = 1'b0;
    din = 16'($urandom);
  endtask

  task automatic idle(input int n, input string name);
    run = 1'b0;
    repeat (n) begin
      din = 16'($urandom);
      @(posedge clock); #1;
      check({name, "_cnt"}, 32'(cnt), 32'd0);
      check({name, "_ir"}, 32'(ir), 32'(m_ir));
    end
  endtask

  // monitor
  always @(negedge clock) begin
    logic [W-1:0] e;
    if (resetn === 1'b0) begin
      if (cnt == 2'd0) begin
        check("t0_bus", 32'(bus), 32'd0);
        check("t0_done", 32'(done), 32'd0);
      end
      if (done) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_done: cnt=%0d ir=%h bus=%h with no expected entry", cnt, ir, bus);
        end else begin
          e = exp_q.pop_front();
          if ({cnt, ir, bus, a, g} !== e) begin
            n_bad++;
            $display("FAIL done_state: got cnt=%0d ir=%h bus=%h a=%h g=%h expected cnt=%0d ir=%h bus=%h a=%h g=%h",
                     cnt, ir, bus, a, g, e[58:57], e[56:48], e[47:32], e[31:16], e[15:0]);
          end
        end
      end
    end
  end

  initial begin
    int k;
    resetn = 1'b1;
    run    = 1'b0;
    din    = '0;
    model_reset();

    // reset held: state stays cleared whatever run/din do
    repeat (3) begin
      run = 1'($urandom);
      din = 16'($urandom);
      @(posedge clock); #1;
      check("rst_cnt", 32'(cnt), 32'd0);
      check("rst_ir", 32'(ir), 32'd0);
      check("rst_a", 32'(a), 32'd0);
      check("rst_g", 32'(g), 32'd0);
      check("rst_bus", 32'(bus), 32'd0);
      check("rst_done", 32'(done), 32'd0);
    end
    run = 1'b0;
    resetn = 1'b0;
    @(posedge clock); #1;

    // directed sequence
    issue(3'd1, 3'd2, 3'd0, 16'h0005);  // mvi R2,5
    issue(3'd0, 3'd5, 3'd2, 16'h0000);  // mv R5,R2
    issue(3'd1, 3'd7, 3'd0, 16'h0006);  // mvi R7,6
    issue(3'd2, 3'd5, 3'd7, 16'h0000);  // add R5,R7 -> 11
    issue(3'd3, 3'd7, 3'd2, 16'h0000);  // sub R7,R2 -> 1
    issue(3'd1, 3'd2, 3'd0, 16'h0006);
    issue(3'd1, 3'd7, 3'd0, 16'h0005);
    issue(3'd3, 3'd7, 3'd2, 16'h0000);  // 5-6 wraps to FFFF
    issue(3'd5, 3'd1, 3'd2, 16'h0000);  // nop
    issue(3'd2, 3'd4, 3'd4, 16'h0000);  // add Rx,Rx with Rx=0
    issue(3'd2, 3'd7, 3'd7, 16'h0000);  // doubles FFFF
    issue(3'd3, 3'd5, 3'd5, 16'h0000);  // clears R5
    issue(3'd1, 3'd5, 3'd0, 16'h1234);
    issue(3'd0, 3'd5, 3'd5, 16'h0000);  // mv Rx,Rx reads back

    idle(5, "idle");

    // reset during T2 of add R5,R7 aborts without writing R5
    din = {3'd2, 3'd5, 3'd7, 7'd0};
    run = 1'b1;
    @(posedge clock); #1;
    run = 1'b0;
    @(posedge clock); #1;
    check("pre_abort_cnt", 32'(cnt), 32'd2);
    resetn = 1'b1;
    #1;
    check("abort_cnt", 32'(cnt), 32'd0);
    check("abort_ir", 32'(ir), 32'd0);
    check("abort_a", 32'(a), 32'd0);
    check("abort_g", 32'(g), 32'd0);
    check("abort_bus", 32'(bus), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    model_reset();
    @(posedge clock); #1;
    resetn = 1'b0;
    issue(3'd0, 3'd5, 3'd5, 16'h0000);
    issue(3'd0, 3'd7, 3'd7, 16'h0000);

    // randomized traffic
    repeat (300) begin
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            16'($urandom));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3), "rand_idle");
    end

    // read back every register
    for (int i = 0; i < 8; i++) issue(3'd0, 3'(i), 3'(i), 16'h0000);

    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      @(posedge clock);
      k++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
